// File: rtl/shooter_velocity_ramp_if.sv
// Command/status bundle between the shooter feed logic and the velocity ramp.
interface shooter_velocity_ramp_if;
  logic        arm;
  logic        target_load;
  logic [31:0] target_velocity;
  logic [31:0] velocity;
  logic        armed;
  logic        at_speed;
  logic [2:0]  state;

  modport master (
    output arm, target_load, target_velocity,
    input  velocity, armed, at_speed, state
  );

  modport slave (
    input  arm, target_load, target_velocity,
    output velocity, armed, at_speed, state
  );
endinterface

// File: rtl/shooter_velocity_ramp.sv
// Shooter ESC command stage: arming hold, target clamp, per-frame bounded slew
// toward the latched target, and an at-speed flag for the feed logic.
module shooter_velocity_ramp #(
  parameter int unsigned MAX_VEL     = 20000,
  parameter int unsigned STEP        = 500,
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned ARM_CYCLES  = 100000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  shooter_velocity_ramp_if.slave  bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMING   = 3'd1,
    IDLE     = 3'd2,
    RAMP     = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t      cur_state, next_state;
  logic [31:0] vel_q, vel_d;
  logic [31:0] target_q;
  logic [31:0] tick_cnt, tick_cnt_d;
  logic [31:0] arm_cnt, arm_cnt_d;
  logic [31:0] gap_up, gap_dn;
  logic        tick;
  logic        armed_q, at_speed_q;

  assign tick = (tick_cnt == TICK_CYCLES - 1);

  always_comb begin
    next_state = cur_state;
    vel_d      = vel_q;
    arm_cnt_d  = arm_cnt;
    tick_cnt_d = '0;
    gap_up     = target_q - vel_q;
    gap_dn     = vel_q - target_q;

    if (cur_state != DISARMED && cur_state != ARMING)
      tick_cnt_d = tick ? '0 : tick_cnt + 32'd1;

    case (cur_state)
      DISARMED: begin
        vel_d     = '0;
        arm_cnt_d = '0;
        if (bus.arm) next_state = ARMING;
      end
      ARMING: begin
        vel_d = '0;
        if (arm_cnt == ARM_CYCLES - 1) next_state = IDLE;
        else                           arm_cnt_d  = arm_cnt + 32'd1;
      end
      IDLE: begin
        vel_d = '0;
        if (target_q != vel_q) next_state = RAMP;
      end
      RAMP: begin
        // Step is limited to the remaining gap so velocity lands exactly on target.
        if (tick) begin
          if (target_q > vel_q)      vel_d = vel_q + ((gap_up > STEP) ? STEP : gap_up);
          else if (target_q < vel_q) vel_d = vel_q - ((gap_dn > STEP) ? STEP : gap_dn);
        end
        if (vel_d == target_q) next_state = HOLD;
      end
      HOLD: begin
        if (target_q != vel_q) next_state = RAMP;
      end
      default: begin
        next_state = DISARMED;
        vel_d      = '0;
      end
    endcase

    // Disarm is a hard cut from any state; no ramp-down.
    if (!bus.arm) begin
      next_state = DISARMED;
      vel_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= DISARMED;
      vel_q      <= '0;
      target_q   <= '0;
      tick_cnt   <= '0;
      arm_cnt    <= '0;
      armed_q    <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      cur_state  <= next_state;
      vel_q      <= vel_d;
      tick_cnt   <= tick_cnt_d;
      arm_cnt    <= arm_cnt_d;
      armed_q    <= (next_state == IDLE) || (next_state == RAMP) || (next_state == HOLD);
      at_speed_q <= (next_state == HOLD);
      if (bus.target_load && bus.arm)
        target_q <= (bus.target_velocity > MAX_VEL) ? MAX_VEL : bus.target_velocity;
    end
  end

  assign bus.velocity = vel_q;
  assign bus.armed    = armed_q;
  assign bus.at_speed = at_speed_q;
  assign bus.state    = cur_state;

endmodule

// File: tb/tb_shooter_velocity_ramp.sv
// Scoreboard bench for shooter_velocity_ramp: directed scenarios then random
// arm/load traffic, all predicted by a behavioural model of the ramp rules.
module tb_shooter_velocity_ramp;
  localparam int unsigned MAX_VEL = 20000;
  localparam int unsigned STEP    = 500;
  localparam int unsigned TICK    = 10;
  localparam int unsigned ARM     = 50;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  shooter_velocity_ramp_if bus();

  shooter_velocity_ramp #(
    .MAX_VEL    (MAX_VEL),
    .STEP       (STEP),
    .TICK_CYCLES(TICK),
    .ARM_CYCLES (ARM)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] vel;
    logic [2:0]  st;
    logic        armed;
    logic        at_speed;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hist[$];
  logic [31:0] last_vel = '0;
  int          arming_samples = 0;

  // Reference model: mode numbers follow the debug state codes.
  int unsigned m_mode = 0, m_vel = 0, m_tgt = 0, m_run = 0, m_arm_elapsed = 0;

  function automatic int unsigned toward(input int unsigned v, input int unsigned t);
    if (t > v) return (t - v > STEP) ? v + STEP : t;
    if (t < v) return (v - t > STEP) ? v - STEP : t;
    return v;
  endfunction

  function automatic void model_step(input bit r, input bit a, input bit l, input logic [31:0] tv);
    int unsigned nm, nv;
    bit          frame;
    exp_t        e;
    if (!r) begin
      m_mode = 0; m_vel = 0; m_tgt = 0; m_run = 0; m_arm_elapsed = 0;
    end else begin
      frame = (m_mode >= 2) && (m_run % TICK == TICK - 1);
      nm = m_mode;
      nv = m_vel;
      case (m_mode)
        0: begin nv = 0; m_arm_elapsed = 0; if (a) nm = 1; end
        1: begin
          nv = 0;
          if (m_arm_elapsed == ARM - 1) nm = 2;
          else m_arm_elapsed = m_arm_elapsed + 1;
        end
        2: begin nv = 0; if (m_tgt != 0) nm = 3; end
        3: begin
          if (frame) nv = toward(m_vel, m_tgt);
          if (nv == m_tgt) nm = 4;
        end
        default: if (m_tgt != m_vel) nm = 3;
      endcase
      m_run = (m_mode >= 2) ? m_run + 1 : 0;
      if (!a) begin nm = 0; nv = 0; end
      if (a && l) m_tgt = (tv > MAX_VEL) ? MAX_VEL : tv;
      m_mode = nm;
      m_vel  = nv;
    end
    e.vel      = m_vel;
    e.st       = m_mode[2:0];
    e.armed    = (m_mode >= 2);
    e.at_speed = (m_mode == 4);
    sb.push_back(e);
  endfunction

  task automatic drive(input bit r, input bit a, input bit l, input logic [31:0] tv);
    @(negedge clock);
    reset_n             = r;
    bus.arm             = a;
    bus.target_load     = l;
    bus.target_velocity = tv;
    model_step(r, a, l, tv);
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_hist(input string name, input logic [31:0] expq[$], input bit exact);
    n_checks++;
    if (exact ? (hist.size() != expq.size()) : (hist.size() < expq.size())) begin
      n_fail++;
      $display("FAIL %s length: got %0d velocity steps, expected %0d", name, hist.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < hist.size(); i++)
      check(name, hist[i], expq[i]);
  endtask

  // Monitor: compares every sampled output set against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus.velocity !== last_vel) begin
        hist.push_back(bus.velocity);
        last_vel = bus.velocity;
      end
      if (bus.state == 3'd1) arming_samples++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (bus.velocity !== e.vel || bus.state !== e.st ||
            bus.armed !== e.armed || bus.at_speed !== e.at_speed) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: velocity=%0d/%0d state=%0d/%0d armed=%0b/%0b at_speed=%0b/%0b (got/expected)",
                   $time, bus.velocity, e.vel, bus.state, e.st, bus.armed, e.armed, bus.at_speed, e.at_speed);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] expq[$];
    logic [31:0] vmax;
    bit a, l;
    logic [31:0] tv;

    bus.arm = 1'b0;
    bus.target_load = 1'b0;
    bus.target_velocity = '0;

    repeat (3) drive(0, 0, 0, 0);
    repeat (60) drive(1, 1, 0, 0);
    check("arming duration", arming_samples, 50);
    check("idle after arming", {29'b0, bus.state}, 32'd2);

    hist.delete();
    drive(1, 1, 1, 2000);
    repeat (50) drive(1, 1, 0, 0);
    expq = {32'd500, 32'd1000, 32'd1500, 32'd2000};
    check_hist("ramp up to 2000", expq, 1'b1);
    check("at_speed at 2000", {31'b0, bus.at_speed}, 32'd1);

    hist.delete();
    drive(1, 1, 1, 1200);
    repeat (30) drive(1, 1, 0, 0);
    expq = {32'd1500, 32'd1200};
    check_hist("partial step down to 1200", expq, 1'b1);

    hist.delete();
    drive(1, 1, 1, 0);
    repeat (40) drive(1, 1, 0, 0);
    expq = {32'd700, 32'd200, 32'd0};
    check_hist("ramp down to 0", expq, 1'b1);
    check("hold at zero", {29'b0, bus.state}, 32'd4);

    hist.delete();
    drive(1, 1, 1, 30000);
    repeat (430) drive(1, 1, 0, 0);
    vmax = '0;
    foreach (hist[i]) if (hist[i] > vmax) vmax = hist[i];
    check("clamped ramp step count", hist.size(), 40);
    check("clamped ramp peak", vmax, 20000);
    check("clamped ramp final", bus.velocity, 20000);

    // Disarm together with a load: load must be dropped, 20000 retained.
    drive(1, 0, 1, 1000);
    check("disarm cut", bus.velocity, 0);
    hist.delete();
    arming_samples = 0;
    for (int i = 0; i < 300 && bus.velocity != 1000; i++) drive(1, 1, 0, 0);
    check("reached 1000 after re-arm", bus.velocity, 1000);
    check("re-arm duration", arming_samples, 50);
    drive(1, 0, 0, 0);
    check("mid-ramp disarm state", {29'b0, bus.state}, 32'd0);
    check("mid-ramp disarm armed", {31'b0, bus.armed}, 32'd0);

    hist.delete();
    repeat (100) drive(1, 1, 0, 0);
    expq = {32'd0, 32'd500, 32'd1000, 32'd1500};
    expq.delete(0);
    check_hist("retained target ramp", expq, 1'b0);
    check("mid-ramp before reset", {29'b0, bus.state}, 32'd3);

    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async reset velocity", bus.velocity, 0);
    check("async reset state", {29'b0, bus.state}, 32'd0);
    check("async reset armed", {31'b0, bus.armed}, 32'd0);
    check("async reset at_speed", {31'b0, bus.at_speed}, 32'd0);
    model_step(0, bus.arm, 1'b0, '0);
    @(posedge clock);
    #2;
    repeat (2) drive(0, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      a  = ($urandom_range(0, 299) != 0);
      l  = ($urandom_range(0, 29) == 0);
      tv = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 25000);
      drive(1, a, l, tv);
    end

    repeat (2) drive(1, 1, 0, 0);
    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
